// File: rtl/cnn_window_gen_pkg.sv
// Shared definitions for the CNN window generator.
// Holds the image geometry, derived widths, the counter boundary constants
// and the controller state encoding used by cnn_window_gen and
// cnn_line_buffer.
package cnn_window_gen_pkg;

  localparam int IMG_W    = 28;              // image width in pixels
  localparam int IMG_H    = 28;              // image height in pixels
  localparam int K        = 5;               // window edge
  localparam int PIX_W    = 8;               // pixel width in bits
  localparam int OUT_W    = IMG_W - K + 1;   // window columns per row (24)
  localparam int OUT_H    = IMG_H - K + 1;   // window rows per frame (24)
  localparam int WIN_BITS = K * K * PIX_W;   // flattened window width (200)

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int XY_W  = $clog2((OUT_W > OUT_H) ? OUT_W : OUT_H);

  // Counter boundaries, pre-sized so compares need no width juggling.
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(K - 1);
  localparam logic [XY_W-1:0]  X_LAST        = XY_W'(OUT_W - 1);
  localparam logic [XY_W-1:0]  Y_LAST        = XY_W'(OUT_H - 1);

  // One column of the line buffer: [0] = newest row (r-1), [K-2] = oldest (r-K+1).
  typedef logic [K-2:0][PIX_W-1:0] lb_col_t;

  typedef enum logic [1:0] {
    ST_LOAD      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cnn_line_buffer.sv
// Line buffer holding the last K-1 image rows.
// Each column entry is a small vertical shift register: writing a pixel at a
// column pushes it in as the newest row and drops the oldest. The read port
// is combinational on the same column, so the caller sees the K-1 pixels
// stored above the pixel being written (read-before-write).
//
// Ports:
//   CLK        clock
//   wr_en_i    write the pixel at col_i this cycle
//   col_i      column being read and written
//   pix_i      pixel to write
//   col_pix_o  stored pixels of column col_i, [0] = row r-1 .. [K-2] = row r-K+1
module cnn_line_buffer
  import cnn_window_gen_pkg::*;
(
  input  logic             CLK,
  input  logic             wr_en_i,
  input  logic [COL_W-1:0] col_i,
  input  logic [PIX_W-1:0] pix_i,
  output lb_col_t          col_pix_o
);

  lb_col_t mem_q [IMG_W];

  assign col_pix_o = mem_q[col_i];

  // NOTE: the storage array has no reset: it is plain RAM, and no window is
  // issued until K-1 fresh rows of the current frame have overwritten it.
  // NOTE: clocked state uses non-blocking assignment so the combinational
  // read above sees the pre-edge contents in the same cycle as the write.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[col_i] <= {mem_q[col_i][K-3:0], pix_i};
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Window generator feeding the CNN core.
// Accepts a raster-order pixel stream, keeps K-1 rows in a line buffer plus a
// KxK shift window, and hands each complete window to the core with a
// START/DONE handshake. One window is in flight at a time; the pixel input is
// stalled (PIX_READY=0) from the issue until the core reports DONE.
//
// Ports:
//   CLK, nRST    clock, asynchronous active-low reset
//   PIX_VALID    pixel present on PIX_DATA
//   PIX_DATA     unsigned pixel
//   PIX_SOF      current pixel is (0,0) of a new frame
//   PIX_READY    pixel accepted this cycle when PIX_VALID is high
//   CNN_START    one-cycle pulse, X/Y/IMGIN valid
//   X, Y         top-left column/row of the window
//   IMGIN        window, IMGIN[(i*K+j)*PIX_W +: PIX_W] = pixel(Y+i, X+j)
//   CNN_DONE     core finished the current window (sampled in WAIT_DONE only)
//   FRAME_DONE   one-cycle pulse after the DONE of the last window
module cnn_window_gen
  import cnn_window_gen_pkg::*;
(
  input  logic                CLK,
  input  logic                nRST,
  input  logic                PIX_VALID,
  input  logic [PIX_W-1:0]    PIX_DATA,
  input  logic                PIX_SOF,
  output logic                PIX_READY,
  output logic                CNN_START,
  output logic [XY_W-1:0]     X,
  output logic [XY_W-1:0]     Y,
  output logic [WIN_BITS-1:0] IMGIN,
  input  logic                CNN_DONE,
  output logic                FRAME_DONE
);

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d, cur_col;
  logic [ROW_W-1:0]      row_q, row_d, cur_row;
  logic [PIX_W-1:0]      win_q [K][K];
  logic [PIX_W-1:0]      win_d [K][K];
  logic [XY_W-1:0]       x_q, x_d, y_q, y_d;
  logic [WIN_BITS-1:0]   imgin_q, imgin_d;
  logic                  pix_ready_q, cnn_start_q, frame_done_q, frame_done_d;
  logic                  accept;
  lb_col_t               lb_col;

  assign accept = (state_q == ST_LOAD) && pix_ready_q && PIX_VALID;

  // A start-of-frame pixel is processed as (0,0) regardless of the counters.
  assign cur_col = PIX_SOF ? '0 : col_q;
  assign cur_row = PIX_SOF ? '0 : row_q;

  cnn_line_buffer u_line_buffer (
    .CLK       (CLK),
    .wr_en_i   (accept),
    .col_i     (cur_col),
    .pix_i     (PIX_DATA),
    .col_pix_o (lb_col)
  );

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    x_d          = x_q;
    y_d          = y_q;
    imgin_d      = imgin_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          // Shift the window one column left; new right column comes from
          // the line buffer (older rows) plus the incoming pixel.
          for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
              win_d[i][j] = win_q[i][j+1];
            end
          end
          for (int i = 0; i < K - 1; i++) begin
            win_d[i][K-1] = lb_col[K-2-i];
          end
          win_d[K-1][K-1] = PIX_DATA;

          if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
          end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
          end

          // Only once K columns of this row have shifted in does the window
          // hold real data; earlier columns are stale from the previous row.
          if (cur_row >= ROW_FIRST_WIN && cur_col >= COL_FIRST_WIN) begin
            x_d = XY_W'(cur_col - COL_FIRST_WIN);
            y_d = XY_W'(cur_row - ROW_FIRST_WIN);
            for (int i = 0; i < K; i++) begin
              for (int j = 0; j < K; j++) begin
                imgin_d[(i*K+j)*PIX_W +: PIX_W] = win_d[i][j];
              end
            end
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: state_d = ST_WAIT_DONE;

      ST_WAIT_DONE: begin
        if (CNN_DONE) begin
          state_d = ST_LOAD;
          if (x_q == X_LAST && y_q == Y_LAST) begin
            frame_done_d = 1'b1;
            col_d        = '0;
            row_d        = '0;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_LOAD;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      x_q          <= '0;
      y_q          <= '0;
      imgin_q      <= '0;
      pix_ready_q  <= 1'b0;
      cnn_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      x_q          <= x_d;
      y_q          <= y_d;
      imgin_q      <= imgin_d;
      // Registered from the next state so both are 0 in reset and READY
      // first rises on the clock after reset release.
      pix_ready_q  <= (state_d == ST_LOAD);
      cnn_start_q  <= (state_d == ST_ISSUE);
      frame_done_q <= frame_done_d;
    end
  end

  assign PIX_READY  = pix_ready_q;
  assign CNN_START  = cnn_start_q;
  assign X          = x_q;
  assign Y          = y_q;
  assign IMGIN      = imgin_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen.
// A negedge process acts as the CNN core: it checks every CNN_START window
// against a ramp-image model, checks the window is held while it waits, and
// answers with a one-cycle DONE after a configurable delay. The main process
// streams frames and runs the table of hand-computed window bytes plus the
// multi-cycle corner sequences.
module tb_cnn_window_gen;

  logic         CLK;
  logic         nRST;
  logic         PIX_VALID;
  logic [7:0]   PIX_DATA;
  logic         PIX_SOF;
  logic         PIX_READY;
  logic         CNN_START;
  logic [4:0]   X;
  logic [4:0]   Y;
  logic [199:0] IMGIN;
  logic         CNN_DONE;
  logic         FRAME_DONE;

  cnn_window_gen dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .PIX_VALID  (PIX_VALID),
    .PIX_DATA   (PIX_DATA),
    .PIX_SOF    (PIX_SOF),
    .PIX_READY  (PIX_READY),
    .CNN_START  (CNN_START),
    .X          (X),
    .Y          (Y),
    .IMGIN      (IMGIN),
    .CNN_DONE   (CNN_DONE),
    .FRAME_DONE (FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Written by the main process, read by the core model.
  int dly             = 3;
  int bp_until        = 0;
  int frame_start_idx = 0;
  int pix_count       = 0;
  bit done_in_issue   = 1'b0;
  bit spur_load       = 1'b0;

  // Written by the core model, read by the main process.
  int n_start         = 0;
  int fd_count        = 0;
  int countdown       = 0;
  int last_done_cyc   = 0;
  int first_start_cyc = 0;
  int first_start_pix = 0;
  logic [199:0] cap [24][24];

  // Main-process bookkeeping.
  int last_acc_cyc = 0;
  int acc44_cyc    = 0;

  typedef struct {
    int x;
    int y;
    int i;
    int j;
    int exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Ramp image: pixel(r,c) = (r*28+c) mod 256.
  function automatic logic [199:0] model_window(input int x, input int y);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        w[(i*5+j)*8 +: 8] = 8'(((y + i) * 28 + x + j) % 256);
      end
    end
    return w;
  endfunction

  // ---------------- core model / monitor ----------------
  int           widx, ex, ey;
  logic [4:0]   held_x, held_y;
  logic [199:0] held_img;

  initial begin : core_model
    CNN_DONE = 1'b0;
    forever begin
      @(negedge CLK);
      CNN_DONE = 1'b0;
      if (!nRST) begin
        countdown = 0;
      end else begin
        if (CNN_START) begin
          widx = n_start - frame_start_idx;
          ex   = widx % 24;
          ey   = (widx / 24) % 24;
          check("start_x", int'(X), ex);
          check("start_y", int'(Y), ey);
          check_vec("start_imgin", IMGIN, model_window(ex, ey));
          if (widx == 0) begin
            first_start_cyc = cyc;
            first_start_pix = pix_count;
          end
          cap[ey][ex] = IMGIN;
          held_x   = X;
          held_y   = Y;
          held_img = IMGIN;
          countdown = (n_start < bp_until) ? 50 : dly;
          n_start++;
          if (done_in_issue) CNN_DONE = 1'b1;
        end else if (countdown > 0) begin
          check("hold_ready_low", int'(PIX_READY), 0);
          check("hold_start_low", int'(CNN_START), 0);
          check("hold_x", int'(X), int'(held_x));
          check("hold_y", int'(Y), int'(held_y));
          check_vec("hold_imgin", IMGIN, held_img);
          countdown--;
          if (countdown == 0) begin
            CNN_DONE      = 1'b1;
            last_done_cyc = cyc;
          end
        end else if (spur_load && pix_count < 100) begin
          CNN_DONE = 1'b1;
          check("spurious_done_ready", int'(PIX_READY), 1);
        end
        if (FRAME_DONE) begin
          fd_count++;
          check("frame_done_timing", cyc, last_done_cyc + 1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_pixel(input int r, input int c, input bit sof, input bit gaps);
    bit ok;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        PIX_VALID = 1'b0;
        tick();
      end
    end
    PIX_VALID = 1'b1;
    PIX_DATA  = 8'((r * 28 + c) % 256);
    PIX_SOF   = sof;
    ok = 1'b0;
    for (int w = 0; w < 3000 && !ok; w++) begin
      @(negedge CLK);
      ok = PIX_READY;
      if (ok) last_acc_cyc = cyc;
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL pixel_accept_timeout: pixel (%0d,%0d) never accepted", r, c);
    end
    pix_count++;
    PIX_VALID = 1'b0;
    PIX_SOF   = 1'b0;
  endtask

  task automatic send_frame(input int n_pix, input bit sof, input bit gaps);
    pix_count = 0;
    for (int p = 0; p < n_pix; p++) begin
      send_pixel(p / 28, p % 28, sof && (p == 0), gaps);
      if (p == 4 * 28 + 4) acc44_cyc = last_acc_cyc;
    end
  endtask

  task automatic frame_checks(input int start_base, input int fd_base);
    for (int w = 0; w < 500 && fd_count == fd_base; w++) tick();
    repeat (3) tick();
    check("frame_windows", n_start - start_base, 576);
    check("frame_done_pulses", fd_count - fd_base, 1);
    check("first_start_latency", first_start_cyc, acc44_cyc + 1);
    check("first_start_pixels", first_start_pix, 117);
  endtask

  task automatic table_checks();
    logic [199:0] w;
    for (int k = 0; k < 10; k++) begin
      w = cap[vecs[k].y][vecs[k].x];
      check($sformatf("vec%0d_x%0d_y%0d_byte%0d", k, vecs[k].x, vecs[k].y, vecs[k].i * 5 + vecs[k].j),
            int'(w[(vecs[k].i * 5 + vecs[k].j) * 8 +: 8]), vecs[k].exp);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  int sb, fb;

  initial begin : main
    // Hand-computed window bytes of the ramp frame: pixel(Y+i, X+j).
    vecs[0] = '{x: 0,  y: 0,  i: 0, j: 0, exp: 0};    // (0,0)
    vecs[1] = '{x: 0,  y: 0,  i: 4, j: 4, exp: 116};  // (4,4)
    vecs[2] = '{x: 0,  y: 0,  i: 2, j: 3, exp: 59};   // (2,3)
    vecs[3] = '{x: 23, y: 23, i: 0, j: 0, exp: 155};  // (23,23) 667 mod 256
    vecs[4] = '{x: 23, y: 23, i: 4, j: 4, exp: 15};   // (27,27) 783 mod 256
    vecs[5] = '{x: 23, y: 0,  i: 0, j: 4, exp: 27};   // (0,27)
    vecs[6] = '{x: 0,  y: 23, i: 4, j: 0, exp: 244};  // (27,0) 756 mod 256
    vecs[7] = '{x: 5,  y: 2,  i: 1, j: 3, exp: 92};   // (3,8)
    vecs[8] = '{x: 10, y: 7,  i: 2, j: 0, exp: 6};    // (9,10) 262 mod 256
    vecs[9] = '{x: 12, y: 12, i: 2, j: 2, exp: 150};  // (14,14) 406 mod 256

    nRST      = 1'b0;
    PIX_VALID = 1'b0;
    PIX_DATA  = 8'd0;
    PIX_SOF   = 1'b0;

    // Reset values.
    repeat (3) tick();
    check("rst_ready", int'(PIX_READY), 0);
    check("rst_start", int'(CNN_START), 0);
    check("rst_x", int'(X), 0);
    check("rst_y", int'(Y), 0);
    check_vec("rst_imgin", IMGIN, '0);
    check("rst_frame_done", int'(FRAME_DONE), 0);
    #2 nRST = 1'b1;
    #1 check("ready_before_first_clk", int'(PIX_READY), 0);
    tick();
    check("ready_after_first_clk", int'(PIX_READY), 1);

    // Frame A: ramp, DONE after 3 cycles, spurious DONE while loading rows 0-3.
    sb = n_start; fb = fd_count; frame_start_idx = n_start;
    spur_load = 1'b1;
    send_frame(784, 1'b1, 1'b0);
    spur_load = 1'b0;
    frame_checks(sb, fb);
    table_checks();

    // Frame B: random PIX_VALID gaps, DONE also raised during ISSUE.
    sb = n_start; fb = fd_count; frame_start_idx = n_start;
    done_in_issue = 1'b1;
    send_frame(784, 1'b1, 1'b1);
    frame_checks(sb, fb);
    done_in_issue = 1'b0;
    table_checks();

    // Frame C: backpressure, DONE delayed 50 cycles for the first 40 windows.
    sb = n_start; fb = fd_count; frame_start_idx = n_start;
    bp_until = n_start + 40;
    send_frame(784, 1'b1, 1'b0);
    frame_checks(sb, fb);

    // Frame D aborted by SOF at pixel (10,7): 6 full window rows + 3 windows.
    sb = n_start; fb = fd_count; frame_start_idx = n_start;
    send_frame(10 * 28 + 7, 1'b1, 1'b0);
    repeat (12) tick();
    check("abort_windows", n_start - sb, 147);
    check("abort_no_frame_done", fd_count - fb, 0);
    sb = n_start; fb = fd_count; frame_start_idx = n_start;
    send_frame(784, 1'b1, 1'b0);
    frame_checks(sb, fb);

    // Reset while waiting for DONE on window (X=5,Y=1).
    sb = n_start; frame_start_idx = n_start;
    send_frame(149, 1'b1, 1'b0);
    repeat (10) tick();
    dly = 10000;
    send_pixel(5, 9, 1'b0, 1'b0);
    repeat (5) tick();
    check("pre_reset_windows", n_start - sb, 30);
    check("pre_reset_x", int'(X), 5);
    check("pre_reset_y", int'(Y), 1);
    check("pre_reset_ready", int'(PIX_READY), 0);
    #2 nRST = 1'b0;
    #1;
    check("async_rst_ready", int'(PIX_READY), 0);
    check("async_rst_start", int'(CNN_START), 0);
    check("async_rst_x", int'(X), 0);
    check("async_rst_y", int'(Y), 0);
    check_vec("async_rst_imgin", IMGIN, '0);
    check("async_rst_frame_done", int'(FRAME_DONE), 0);
    dly = 3;
    repeat (2) tick();
    #2 nRST = 1'b1;
    #1 check("rerelease_ready_before_clk", int'(PIX_READY), 0);
    tick();
    check("rerelease_ready_after_clk", int'(PIX_READY), 1);

    // Frame after reset, streamed without SOF: counters must start at 0.
    sb = n_start; fb = fd_count; frame_start_idx = n_start;
    send_frame(784, 1'b0, 1'b0);
    frame_checks(sb, fb);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Upstream feeder for the simple CNN core.
- Accepts a 28x28 8-bit image as a raster-order pixel stream with a valid/ready handshake.
- Buffers the last four rows in line buffers and presents each 5x5 window (576 per frame) with its X/Y coordinates.
- Drives the core's START/DONE handshake, issuing one window at a time and holding it stable until the core reports DONE.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, window edge; output windows per frame = (IMG_W-K+1)*(IMG_H-K+1) = 576
- PIX_W, 8, pixel width in bits

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- PIX_VALID  in  1  pixel present on PIX_DATA
- PIX_DATA  in  8  unsigned pixel
- PIX_SOF  in  1  qualifies the current pixel as pixel (0,0) of a new frame
- PIX_READY  out  1  block accepts a pixel this cycle
- CNN_START  out  1  one-cycle pulse: window on X/Y/IMGIN is valid
- X  out  5  window top-left column, 0..23
- Y  out  5  window top-left row, 0..23
- IMGIN  out  200  window; IMGIN[(i*5+j)*8 +: 8] = pixel(row Y+i, col X+j)
- CNN_DONE  in  1  core finished the current window
- FRAME_DONE  out  1  one-cycle pulse after the DONE of the 576th window

Behaviour:
- Reset: nRST is asynchronous, active-low; clock is CLK.
  - All outputs reset to 0: PIX_READY=0, CNN_START=0, X=0, Y=0, IMGIN=0, FRAME_DONE=0.
  - State = LOAD; row/col counters = 0; shift window cleared.
  - PIX_READY rises on the first clock after reset release.
- States: LOAD, ISSUE, WAIT_DONE.
- LOAD:
  - PIX_READY=1. A pixel is accepted when PIX_VALID && PIX_READY.
  - On accept, write the pixel to the line buffer at column col.
  - Shift the 5x5 window one column left; the new right column = {linebuf rows r-4..r-1 at col, new pixel}.
  - Advance col; on col wrap (27->0), advance row.
  - If the accepted pixel has row>=4 and col>=4, latch X=col-4, Y=row-4 and the window into IMGIN, then go to ISSUE.
  - Otherwise stay in LOAD.
- ISSUE (exactly 1 cycle):
  - CNN_START=1, PIX_READY=0.
  - Next state WAIT_DONE.
  - Latency: accept cycle t -> CNN_START high in cycle t+1.
- WAIT_DONE:
  - PIX_READY=0. X/Y/IMGIN are held constant.
  - CNN_DONE is sampled level-high, only in this state; CNN_DONE outside WAIT_DONE is ignored.
  - On CNN_DONE, if (X,Y)==(23,23): FRAME_DONE=1 for 1 cycle, counters reset to 0, go to LOAD.
  - On CNN_DONE otherwise: go to LOAD.
- Row/column boundaries:
  - Pixels with col<4 or row<4 are buffered only; no window is issued.
  - At the start of each row the shift window holds stale columns, but no window is issued until 4 new columns have shifted in.
- Frame sync:
  - An accepted pixel with PIX_SOF=1 forces row=col=0 before being processed as pixel (0,0). A partial frame is abandoned with no FRAME_DONE.
  - PIX_SOF on a non-accepted cycle is ignored.
- Counter arithmetic: widths are sized with $clog2 from the parameters; no arithmetic beyond counter compare/increment.
- Reset mid-operation (any state, including WAIT_DONE): immediate return to reset values. A window already issued is not re-issued.

Decomposition:
- Shared package/header holds: IMG_W, IMG_H, K, PIX_W, derived OUT_W=IMG_W-K+1, window bit width K*K*PIX_W (=200), and state encodings.
- One sub-module: cnn_line_buffer.
  - K-1 rows by IMG_W deep, PIX_W wide.
  - Read-before-write at the same column.
  - Outputs the K-1 stored pixels of the column being written.

Test Plan:
- Ramp frame, pixel(r,c)=(r*28+c) mod 256, with a DONE responder at 3 cycles:
  - First CNN_START comes 1 cycle after pixel (4,4) is accepted, with X=0, Y=0 and IMGIN byte (i*5+j) = i*28+j.
  - Exactly 576 STARTs occur in raster order of (X,Y).
  - Last START has X=23, Y=23 and byte 0 = 155.
  - FRAME_DONE pulses once, 1 cycle after the last DONE.
- Backpressure: DONE delayed 50 cycles -> PIX_READY=0 and X/Y/IMGIN constant throughout WAIT_DONE; no pixel is lost (the window contents check still passes).
- Random PIX_VALID gaps (50% duty) -> identical window sequence to the gap-free run.
- PIX_SOF asserted at pixel (10,7) of a frame -> no FRAME_DONE for the aborted frame; next window is X=0, Y=0 after 4 rows + 5 pixels.
- CNN_DONE asserted in LOAD or ISSUE -> ignored; no extra state change.
- nRST pulled low in WAIT_DONE -> all outputs 0 asynchronously; after release PIX_READY=1 and the next frame produces 576 windows.
